hazard_unit_mc: RTL and testbench
=================================

# hazard_unit_mc

Parametrised successor to the pipelined core's hazard unit. It keeps the existing forwarding, load-use stall and branch flush rules, and adds support for a variable-latency execute unit such as a multiply/divide unit. That support is a cycle scoreboard that holds the Execute stage for `MC_LAT` cycles and injects bubbles into Memory. It also adds saturating performance counters for stall and flush events. It sits beside the datapath in the core top and drives its stall, flush and forward controls.

## Interface
Parameters:
- `ADDR_W`, 5, register address width; register 0 is hard-wired zero.
- `MC_LAT`, 4, Execute-stage residency in cycles of a multi-cycle op; legal range 1..255.
- `CNT_W`, 32, width of each performance counter.

Ports:
- `clk`  in  1  core clock; single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `Rs1D`, `Rs2D`  in  ADDR_W each  source registers in Decode.
- `Rs1E`, `Rs2E`, `RdE`  in  ADDR_W each  sources and destination in Execute.
- `ResultSrcE`  in  2  result select in Execute; `2'b01` means load.
- `MultiCycleE`  in  1  the Execute instruction is a multi-cycle op.
- `PCSrcE`  in  1  taken branch or jump resolved in Execute.
- `RdM`  in  ADDR_W  destination in Memory.
- `RegWriteM`  in  1  write enable in Memory.
- `RdW`  in  ADDR_W  destination in Writeback.
- `RegWriteW`  in  1  write enable in Writeback.
- `StallF`, `StallD`, `StallE`  out  1 each  hold the Fetch, Decode and Execute registers.
- `FlushD`, `FlushE`, `FlushM`  out  1 each  bubble into the Decode, Execute and Memory registers.
- `ForwardAE`, `ForwardBE`  out  2 each  operand source: `00` register file, `01` Writeback result, `10` Memory ALU result.
- `BusyE`  out  1  a multi-cycle op is holding Execute.
- `LoadUseCnt`, `McStallCnt`, `FlushCnt`  out  CNT_W each  performance counters.

## Operation
- **Forwarding (combinational), operand A:**
  - `ForwardAE=10` if `RegWriteM`, `RdM!=0` and `RdM==Rs1E`.
  - Else `01` if `RegWriteW`, `RdW!=0` and `RdW==Rs1E`.
  - Else `00`.
  - Memory stage has priority over Writeback.
- **Forwarding, operand B:** same rules with `Rs2E` producing `ForwardBE`.
- **Multi-cycle scoreboard:** register `mc_cnt` is 8 bits wide, reset value 0.
  - `mc_cnt==0` and `MultiCycleE=1`: load `mc_cnt <= MC_LAT-1`.
  - `mc_cnt>1`: decrement.
  - `mc_cnt==1`: clear to 0; the op leaves Execute next edge.
  - `BusyE = MultiCycleE & ((mc_cnt==0 & MC_LAT>1) | mc_cnt>1)`.
- **While `BusyE`:**
  - `StallF=StallD=StallE=1`, `FlushM=1`.
  - `FlushE=0`, `FlushD=0`.
  - Load-use detection and `PCSrcE` are ignored; neither can legally coincide with a multi-cycle op.
- **Load-use hazard (only when `!BusyE`):**
  - Condition: `lwStall = (ResultSrcE==01) & RdE!=0 & (RdE==Rs1D | RdE==Rs2D)`.
  - Response: `StallF=StallD=1`, `FlushE=1`.
- **Branch:** `PCSrcE & !BusyE` gives `FlushD=1` and `FlushE=1`. `FlushE = lwStall | PCSrcE` when not busy.
- **Counters:** each counter increments by 1 on every cycle its event is asserted and saturates at all-ones; it never wraps.
  - `LoadUseCnt` counts `lwStall & !BusyE`.
  - `McStallCnt` counts `BusyE`.
  - `FlushCnt` counts `PCSrcE & !BusyE`.
- **Reset:**
  - Cleared: `mc_cnt`, all counters, `StallF/D/E`, `BusyE`, `ForwardAE/BE`.
  - Forced to 1: `FlushD`, `FlushE`, `FlushM`.
  - Reset asserted mid multi-cycle op aborts it; `mc_cnt` is 0 on the following cycle.

## Timing
- Stall, flush, forward and `BusyE` outputs are combinational from inputs and `mc_cnt`, valid in the same cycle.
- A multi-cycle op occupies Execute for exactly `MC_LAT` cycles and asserts `BusyE` for `MC_LAT-1` of them.
- With `MC_LAT=1`: `BusyE` never asserts and `mc_cnt` stays 0.
- Back-to-back multi-cycle ops: the second sees `mc_cnt==0` on its first Execute cycle and reloads, with no idle gap.
- Counters update on the clock edge after the event cycle.
- Load-use costs exactly one bubble.
- A taken branch costs two flushed slots.

## Test plan
- **Forwarding:** `RdM=RdW=Rs1E=5`, `RegWriteM=RegWriteW=1` -> `ForwardAE=10`. Same with `RegWriteM=0` -> `01`. `Rs1E=0` -> `00`.
- **Load-use:** `ResultSrcE=01`, `RdE=3`, `Rs2D=3` -> `StallF=StallD=FlushE=1` for one cycle; `LoadUseCnt` 0->1.
- **Multi-cycle op, `MC_LAT=4`:** `MultiCycleE` held for 4 cycles -> `BusyE` and `FlushM` high for cycles 0-2, low on cycle 3; `mc_cnt` sequence 0,3,2,1,0; `McStallCnt=3`.
- **Degenerate latency, `MC_LAT=1`:** `MultiCycleE=1` -> `BusyE` never asserts. Taken branch `PCSrcE=1` -> `FlushD=FlushE=1`; `FlushCnt` increments.
- **Reset mid-op:** assert `reset` at `mc_cnt=2` -> next cycle `mc_cnt=0`, counters 0, flushes high. With `CNT_W=4`, preload to 15 via 15 events, then one more event -> stays 15.

Source files
------------

// File: rtl/hazard_unit_mc_if.sv
// hazard_unit_mc_if: datapath <-> hazard unit control bundle
// master: datapath side, drives pipeline register fields and receives controls
// slave:  hazard unit side, samples pipeline fields and drives stall/flush/forward/counters
interface hazard_unit_mc_if #(
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 32
);
    logic [ADDR_W-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic [1:0]        ResultSrcE;
    logic              MultiCycleE, PCSrcE, RegWriteM, RegWriteW;
    logic              StallF, StallD, StallE, FlushD, FlushE, FlushM, BusyE;
    logic [1:0]        ForwardAE, ForwardBE;
    logic [CNT_W-1:0]  LoadUseCnt, McStallCnt, FlushCnt;
    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, ResultSrcE,
               MultiCycleE, PCSrcE, RegWriteM, RegWriteW,
        input  StallF, StallD, StallE, FlushD, FlushE, FlushM, BusyE,
               ForwardAE, ForwardBE, LoadUseCnt, McStallCnt, FlushCnt
    );
    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, ResultSrcE,
               MultiCycleE, PCSrcE, RegWriteM, RegWriteW,
        output StallF, StallD, StallE, FlushD, FlushE, FlushM, BusyE,
               ForwardAE, ForwardBE, LoadUseCnt, McStallCnt, FlushCnt
    );
endinterface

// File: rtl/hazard_unit_mc.sv
// hazard_unit_mc: forwarding, load-use stall, branch flush and multi-cycle execute hold with perf counters
// clk, reset : single clock, synchronous active-high reset
// hz (slave) : pipeline register fields in; stall/flush/forward controls, BusyE and saturating counters out
module hazard_unit_mc #(
    parameter int ADDR_W = 5,
    parameter int MC_LAT = 4,
    parameter int CNT_W  = 32
) (
    input logic             clk,
    input logic             reset,
    hazard_unit_mc_if.slave hz
);
    localparam logic [ADDR_W-1:0] ZERO     = '0;
    localparam logic [7:0]        MC_LOAD  = 8'(MC_LAT - 1);
    localparam bit                MC_MULTI = (MC_LAT > 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    logic [7:0] mc_cnt;
    logic       lw_stall, busy, lw_ev, br_ev;
    // every control is overridden while reset is held so the pipeline drains to bubbles
    always_comb begin
        busy     = !reset && hz.MultiCycleE && ((mc_cnt == 8'd0 && MC_MULTI) || mc_cnt > 8'd1);
        lw_stall = hz.ResultSrcE == 2'b01 && hz.RdE != ZERO && (hz.RdE == hz.Rs1D || hz.RdE == hz.Rs2D);
        lw_ev    = !reset && !busy && lw_stall;
        br_ev    = !reset && !busy && hz.PCSrcE;
        hz.BusyE  = busy;
        hz.StallF = busy || lw_ev;
        hz.StallD = busy || lw_ev;
        hz.StallE = busy;
        hz.FlushM = reset || busy;
        hz.FlushE = reset || lw_ev || br_ev;
        hz.FlushD = reset || br_ev;
        hz.ForwardAE = reset ? 2'b00 :
                       (hz.RegWriteM && hz.RdM != ZERO && hz.RdM == hz.Rs1E) ? 2'b10 :
                       (hz.RegWriteW && hz.RdW != ZERO && hz.RdW == hz.Rs1E) ? 2'b01 : 2'b00;
        hz.ForwardBE = reset ? 2'b00 :
                       (hz.RegWriteM && hz.RdM != ZERO && hz.RdM == hz.Rs2E) ? 2'b10 :
                       (hz.RegWriteW && hz.RdW != ZERO && hz.RdW == hz.Rs2E) ? 2'b01 : 2'b00;
    end
    // with MC_LAT=1 the load value is 0, so the scoreboard never leaves idle
    always_ff @(posedge clk) begin
        mc_cnt        <= reset ? 8'd0 :
                         mc_cnt > 8'd1 ? mc_cnt - 8'd1 :
                         mc_cnt == 8'd1 ? 8'd0 :
                         hz.MultiCycleE ? MC_LOAD : 8'd0;
        hz.LoadUseCnt <= reset ? '0 : (lw_ev && hz.LoadUseCnt != CNT_MAX) ? hz.LoadUseCnt + CNT_ONE : hz.LoadUseCnt;
        hz.McStallCnt <= reset ? '0 : (busy && hz.McStallCnt != CNT_MAX) ? hz.McStallCnt + CNT_ONE : hz.McStallCnt;
        hz.FlushCnt   <= reset ? '0 : (br_ev && hz.FlushCnt != CNT_MAX) ? hz.FlushCnt + CNT_ONE : hz.FlushCnt;
    end
endmodule

// File: tb/tb_hazard_unit_mc.sv
// tb_hazard_unit_mc: directed checks of forwarding, load-use, multi-cycle hold, branch flush, reset and saturation
`define DRV(i) \
  assign i.Rs1D = Rs1D; assign i.Rs2D = Rs2D; assign i.Rs1E = Rs1E; assign i.Rs2E = Rs2E; \
  assign i.RdE = RdE; assign i.RdM = RdM; assign i.RdW = RdW; assign i.ResultSrcE = ResultSrcE; \
  assign i.MultiCycleE = MultiCycleE; assign i.PCSrcE = PCSrcE; \
  assign i.RegWriteM = RegWriteM; assign i.RegWriteW = RegWriteW;
module tb_hazard_unit_mc;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [1:0] ResultSrcE;
  logic MultiCycleE, PCSrcE, RegWriteM, RegWriteW;
  int checks = 0;
  int errors = 0;
  hazard_unit_mc_if #(.ADDR_W(5), .CNT_W(32)) i4 ();
  hazard_unit_mc_if #(.ADDR_W(5), .CNT_W(32)) i1 ();
  hazard_unit_mc_if #(.ADDR_W(5), .CNT_W(4)) isat ();
  `DRV(i4)
  `DRV(i1)
  `DRV(isat)
  hazard_unit_mc #(.ADDR_W(5), .MC_LAT(4), .CNT_W(32)) u4 (.clk(clk), .reset(reset), .hz(i4.slave));
  hazard_unit_mc #(.ADDR_W(5), .MC_LAT(1), .CNT_W(32)) u1 (.clk(clk), .reset(reset), .hz(i1.slave));
  hazard_unit_mc #(.ADDR_W(5), .MC_LAT(4), .CNT_W(4)) usat (.clk(clk), .reset(reset), .hz(isat.slave));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic idle();
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    ResultSrcE = 2'b00; MultiCycleE = 0; PCSrcE = 0; RegWriteM = 0; RegWriteW = 0;
  endtask
  initial begin
    idle();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    MultiCycleE = 1; PCSrcE = 1; RdM = 5; Rs1E = 5; RegWriteM = 1;
    #1;
    chk("rst_flushd", i4.FlushD, 1'b1);
    chk("rst_flushe", i4.FlushE, 1'b1);
    chk("rst_flushm", i4.FlushM, 1'b1);
    chk("rst_stallf", i4.StallF, 1'b0);
    chk("rst_stalle", i4.StallE, 1'b0);
    chk("rst_busy", i4.BusyE, 1'b0);
    chk("rst_fwda", i4.ForwardAE, 2'b00);
    chk("rst_mc_cnt", u4.mc_cnt, 8'd0);
    @(negedge clk);
    #1;
    chk("rst_mcstall_cnt", i4.McStallCnt, 32'd0);
    chk("rst_flush_cnt", i4.FlushCnt, 32'd0);
    chk("rst_loaduse_cnt", i4.LoadUseCnt, 32'd0);
    chk("rst_mc_cnt_hold", u4.mc_cnt, 8'd0);
    @(negedge clk);
    idle(); reset = 1'b0;
    #1;
    chk("idle_flushd", i4.FlushD, 1'b0);
    chk("idle_flushm", i4.FlushM, 1'b0);
    @(negedge clk);
    RdM = 5; RdW = 5; Rs1E = 5; Rs2E = 5; RegWriteM = 1; RegWriteW = 1;
    #1;
    chk("fwd_a_mem", i4.ForwardAE, 2'b10);
    chk("fwd_b_mem", i4.ForwardBE, 2'b10);
    RegWriteM = 0;
    #1;
    chk("fwd_a_wb", i4.ForwardAE, 2'b01);
    Rs1E = 0;
    #1;
    chk("fwd_a_x0", i4.ForwardAE, 2'b00);
    chk("fwd_b_wb", i4.ForwardBE, 2'b01);
    RegWriteW = 0;
    #1;
    chk("fwd_b_nowr", i4.ForwardBE, 2'b00);
    idle();
    @(negedge clk);
    ResultSrcE = 2'b01; RdE = 3; Rs2D = 3;
    #1;
    chk("lu_stallf", i4.StallF, 1'b1);
    chk("lu_stalld", i4.StallD, 1'b1);
    chk("lu_flushe", i4.FlushE, 1'b1);
    chk("lu_flushd", i4.FlushD, 1'b0);
    chk("lu_stalle", i4.StallE, 1'b0);
    chk("lu_cnt_before", i4.LoadUseCnt, 32'd0);
    @(negedge clk);
    idle();
    #1;
    chk("lu_cnt_after", i4.LoadUseCnt, 32'd1);
    chk("lu_released", i4.StallF, 1'b0);
    ResultSrcE = 2'b00; RdE = 3; Rs1D = 3;
    #1;
    chk("lu_not_load", i4.StallF, 1'b0);
    ResultSrcE = 2'b01; RdE = 0; Rs1D = 0;
    #1;
    chk("lu_x0", i4.StallF, 1'b0);
    idle();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      idle(); MultiCycleE = 1;
      #1;
      chk("mc_cnt_seq", u4.mc_cnt, (i == 0) ? 8'd0 : 8'(4 - i));
      chk("mc_busy", i4.BusyE, (i < 3));
      chk("mc_flushm", i4.FlushM, (i < 3));
      chk("mc_stalle", i4.StallE, (i < 3));
      chk("mc1_busy", i1.BusyE, 1'b0);
      chk("mc1_cnt", u1.mc_cnt, 8'd0);
    end
    @(negedge clk);
    idle();
    #1;
    chk("mc_cnt_done", u4.mc_cnt, 8'd0);
    chk("mc_stall_cnt", i4.McStallCnt, 32'd3);
    chk("mc1_stall_cnt", i1.McStallCnt, 32'd0);
    chk("mcsat_stall_cnt", isat.McStallCnt, 4'd3);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      idle(); MultiCycleE = 1;
      #1;
      chk("b2b_busy", i4.BusyE, (i % 4 != 3));
    end
    @(negedge clk);
    idle();
    #1;
    chk("b2b_stall_cnt", i4.McStallCnt, 32'd9);
    chk("b2b_mc_cnt", u4.mc_cnt, 8'd0);
    @(negedge clk);
    PCSrcE = 1;
    #1;
    chk("br_flushd", i1.FlushD, 1'b1);
    chk("br_flushe", i1.FlushE, 1'b1);
    chk("br_stallf", i1.StallF, 1'b0);
    chk("br1_busy_under_mc", i1.BusyE, 1'b0);
    @(negedge clk);
    idle();
    #1;
    chk("br_flush_cnt", i1.FlushCnt, 32'd1);
    chk("br_flushd_off", i1.FlushD, 1'b0);
    @(negedge clk);
    MultiCycleE = 1; PCSrcE = 1;
    #1;
    chk("busy_ign_br_d", i4.FlushD, 1'b0);
    chk("busy_ign_br_e", i4.FlushE, 1'b0);
    chk("busy_ign_busy", i4.BusyE, 1'b1);
    @(negedge clk);
    PCSrcE = 0;
    #1;
    chk("rmid_cnt3", u4.mc_cnt, 8'd3);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rmid_cnt2", u4.mc_cnt, 8'd2);
    chk("rmid_busy", i4.BusyE, 1'b0);
    chk("rmid_flushd", i4.FlushD, 1'b1);
    chk("rmid_stallf", i4.StallF, 1'b0);
    @(negedge clk);
    #1;
    chk("rmid_cnt0", u4.mc_cnt, 8'd0);
    chk("rmid_mcstall", i4.McStallCnt, 32'd0);
    chk("rmid_flushcnt", i4.FlushCnt, 32'd0);
    chk("rmid_lucnt", i4.LoadUseCnt, 32'd0);
    @(negedge clk);
    idle(); reset = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      PCSrcE = 1;
    end
    @(negedge clk);
    idle();
    #1;
    chk("sat_preload", isat.FlushCnt, 4'd15);
    chk("wide_preload", i4.FlushCnt, 32'd15);
    @(negedge clk);
    PCSrcE = 1;
    @(negedge clk);
    idle();
    #1;
    chk("sat_hold", isat.FlushCnt, 4'd15);
    chk("wide_inc", i4.FlushCnt, 32'd16);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
